fft_bitrev_reorder: RTL and testbench

Output reorder stage placed directly after the last `dif_stage` of the pipelined FFT. It accepts the DIF pipeline's bit-reversed-order sample stream and emits each frame of `2**TOTAL_STAGES` complex samples in natural frequency order. Buffering is ping-pong: one bank is written while the other is read. A start-of-frame strobe marks each output frame.

---
 rtl/fft_bitrev_reorder_pkg.sv | 32 +++
 rtl/fft_bitrev_reorder_sdp_ram.sv | 37 +++
 rtl/fft_bitrev_reorder.sv | 161 ++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: bank/read state encodings and the bit-reverse helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fft_bitrev_reorder_pkg;

  // Widest index the bit-reverse helper handles; callers zero-extend into it.
  localparam int BR_MAXW = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_READY,
    BANK_READING
  } bank_st_t;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_st_t;

  // Reverse the low w bits of v. Bits above w come back as zero.
  function automatic logic [BR_MAXW-1:0] bitrev(input logic [BR_MAXW-1:0] v, input int w);
    logic [BR_MAXW-1:0] rv;
    rv = '0;
    for (int k = 0; k < BR_MAXW; k++) begin
      rv[k] = v[BR_MAXW-1-k];
    end
    // Full-width reversal puts the w interesting bits at the top; slide them down.
    return rv >> (BR_MAXW - w);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: 1 cycle from rd_addr/rd_en to rd_dat; write visible to reads on the next cycle.
// Backpressure: none; rd_dat holds its value while rd_en is low.
// Ports: mclk clock; rst clears only the read register (array is never cleared);
//        wr_en/wr_addr/wr_dat write port; rd_en/rd_addr read request; rd_dat read data.
module fft_bitrev_reorder_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int WIDTH = 20
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge mclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed DIF FFT output frames into natural order via a ping-pong RAM.
// Latency: last sample of a frame at cycle t -> o_vld/o_sof with index 0 at t+2, then N unbroken cycles.
// Backpressure: none; an input landing on a bank still READY/READING is dropped and flagged on o_ovf_strb.
// Ports: mclk clock; i_init sync active-high reset; i_vld/i_I/i_Q input sample stream;
//        o_vld/o_I/o_Q natural-order output; o_sof marks index 0; o_ovf_strb one-cycle drop pulse.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int   W            = 10,
  parameter int   TOTAL_STAGES = 8,
  parameter logic BIT_REVERSE  = 1'b1
) (
  input  logic                mclk,
  input  logic                i_init,
  input  logic                i_vld,
  input  logic signed [W-1:0] i_I,
  input  logic signed [W-1:0] i_Q,
  output logic                o_vld,
  output logic signed [W-1:0] o_I,
  output logic signed [W-1:0] o_Q,
  output logic                o_sof,
  output logic                o_ovf_strb
);

  localparam int N  = 2**TOTAL_STAGES;
  localparam int AW = TOTAL_STAGES + 1;

  typedef struct packed {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
  } iq_t;

  // Write side
  logic [TOTAL_STAGES-1:0] wcnt;
  logic                    wbank;
  logic [TOTAL_STAGES-1:0] waddr_lo;
  logic                    wr_ok;
  logic                    wr_en;
  logic                    wr_wrap;

  // Bank bookkeeping and reader
  bank_st_t                bank_st [2];
  rd_st_t                  rd_st;
  logic                    rd_bank;
  logic [TOTAL_STAGES-1:0] rcnt;
  logic                    rdy0;
  logic                    rdy1;
  logic                    pick_bank;
  logic                    rd_pick;
  logic                    rd_en;
  logic                    rd_take;
  logic                    rd_last;
  logic [AW-1:0]           rd_addr;

  iq_t wr_iq;
  iq_t rd_iq;

  assign wr_ok   = (bank_st[wbank] == BANK_EMPTY) || (bank_st[wbank] == BANK_FILLING);
  assign wr_en   = i_vld && !i_init && wr_ok;
  assign wr_wrap = wr_en && (wcnt == '1);

  assign waddr_lo = BIT_REVERSE ? TOTAL_STAGES'(bitrev(BR_MAXW'(wcnt), TOTAL_STAGES)) : wcnt;

  assign wr_iq.i = i_I;
  assign wr_iq.q = i_Q;

  assign rdy0 = (bank_st[0] == BANK_READY);
  assign rdy1 = (bank_st[1] == BANK_READY);

  // Banks fill alternately, so when both are READY the one wbank points back
  // at is the one that was filled first.
  assign pick_bank = (rdy0 && rdy1) ? wbank : rdy1;

  // Frame start decision is made in IDLE and issues address 0 in the same
  // cycle; that is what lets frames run back to back with no bubble.
  assign rd_pick = (rd_st == RD_IDLE) && (rdy0 || rdy1);
  assign rd_en   = !i_init && (rd_pick || (rd_st == RD_READ));
  assign rd_take = rd_en && (rd_st == RD_IDLE);
  assign rd_last = (rd_st == RD_READ) && (rcnt == '1);

  // rcnt is always zero in IDLE, so it doubles as the address-0 offset.
  assign rd_addr = {((rd_st == RD_READ) ? rd_bank : pick_bank), rcnt};

  always_ff @(posedge mclk) begin
    if (i_init) begin
      wcnt       <= '0;
      wbank      <= 1'b0;
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      rd_st      <= RD_IDLE;
      rd_bank    <= 1'b0;
      rcnt       <= '0;
      o_vld      <= 1'b0;
      o_sof      <= 1'b0;
      o_ovf_strb <= 1'b0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wr_wrap) begin
          wbank <= ~wbank;
        end
      end

      // Writer only touches EMPTY/FILLING banks, reader only READY/READING,
      // so these updates never land on the same bank in one cycle.
      for (int b = 0; b < 2; b++) begin
        if (wr_en && (wbank == 1'(b))) begin
          bank_st[b] <= wr_wrap ? BANK_READY : BANK_FILLING;
        end
        if (rd_take && (pick_bank == 1'(b))) begin
          bank_st[b] <= BANK_READING;
        end
        if (rd_last && (rd_bank == 1'(b))) begin
          bank_st[b] <= BANK_EMPTY;
        end
      end

      if (rd_en) begin
        rcnt <= rcnt + 1'b1;
      end

      case (rd_st)
        RD_IDLE: begin
          if (rd_take) begin
            rd_st   <= RD_READ;
            rd_bank <= pick_bank;
          end
        end
        RD_READ: begin
          if (rcnt == '1) begin
            rd_st <= RD_IDLE;
          end
        end
        default: rd_st <= RD_IDLE;
      endcase

      o_vld      <= rd_en;
      o_sof      <= rd_en && (rcnt == '0);
      o_ovf_strb <= i_vld && !wr_ok;
    end
  end

  fft_bitrev_reorder_sdp_ram #(
    .DEPTH (2 * N),
    .AW    (AW),
    .WIDTH ($bits(iq_t))
  ) u_ram (
    .mclk    (mclk),
    .rst     (i_init),
    .wr_en   (wr_en),
    .wr_addr ({wbank, waddr_lo}),
    .wr_dat  (wr_iq),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_iq)
  );

  assign o_I = rd_iq.i;
  assign o_Q = rd_iq.q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at N = 8.
// Latency: checks t+2 first-output timing and continuity against hand-computed cycles.
// Backpressure: overflow exercised by holding the reader off from the bench.
module tb_fft_bitrev_reorder;

  localparam int W = 10;

  logic                mclk;
  logic                i_init;
  logic                i_vld;
  logic signed [W-1:0] i_I;
  logic signed [W-1:0] i_Q;
  logic                o_vld;
  logic signed [W-1:0] o_I;
  logic signed [W-1:0] o_Q;
  logic                o_sof;
  logic                o_ovf_strb;

  fft_bitrev_reorder #(
    .W            (W),
    .TOTAL_STAGES (3),
    .BIT_REVERSE  (1'b1)
  ) dut (
    .mclk       (mclk),
    .i_init     (i_init),
    .i_vld      (i_vld),
    .i_I        (i_I),
    .i_Q        (i_Q),
    .o_vld      (o_vld),
    .o_I        (o_I),
    .o_Q        (o_Q),
    .o_sof      (o_sof),
    .o_ovf_strb (o_ovf_strb)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Bit-reversed arrival order for an 8-point frame.
  int brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    int c;
    int i;
    int q;
    bit sof;
  } osmp_t;

  osmp_t oq [$];
  int    cyc;
  int    ovf_cnt;
  int    ovf_cyc;
  int    n_chk;
  int    n_err;

  initial begin
    cyc     = 0;
    ovf_cnt = 0;
    ovf_cyc = -1;
  end

  always @(posedge mclk) begin
    osmp_t s;
    cyc++;
    #1;
    if (o_vld) begin
      s.c   = cyc;
      s.i   = int'(o_I);
      s.q   = int'(o_Q);
      s.sof = o_sof;
      oq.push_back(s);
    end
    if (o_ovf_strb) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic put(input logic v, input int iv);
    i_vld = v;
    i_I   = W'(iv);
    i_Q   = W'(-iv);
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      put(1'b0, 0);
    end
  endtask

  // One frame in arrival order; values are natural index + off. t_last is the
  // cycle that carries the 8th sample.
  task automatic send_frame(input int off, input bit gap, output int t_last);
    t_last = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) t_last = cyc;
      put(1'b1, brv[k] + off);
      if (gap) put(1'b0, 0);
    end
  endtask

  // Expect oq[base..base+7] = natural order off..off+7, sof on the first only.
  // first_cyc < 0 skips absolute timing.
  task automatic chk_frame(input string tag, input int base, input int first_cyc, input int off);
    for (int j = 0; j < 8; j++) begin
      if (base + j < oq.size()) begin
        chk({tag, "_i"}, oq[base+j].i, off + j);
        chk({tag, "_q"}, oq[base+j].q, -(off + j));
        chk({tag, "_sof"}, int'(oq[base+j].sof), (j == 0) ? 1 : 0);
        if (first_cyc >= 0) chk({tag, "_cyc"}, oq[base+j].c, first_cyc + j);
      end else begin
        chk({tag, "_missing"}, oq.size(), base + 8);
      end
    end
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    n_chk  = 0;
    n_err  = 0;
    i_init = 1'b1;
    i_vld  = 1'b0;
    i_I    = '0;
    i_Q    = '0;

    // Reset state
    tick(); tick(); tick();
    i_init = 1'b0;
    chk("rst_vld", int'(o_vld), 0);
    chk("rst_sof", int'(o_sof), 0);
    chk("rst_ovf", int'(o_ovf_strb), 0);
    chk("rst_I", int'(o_I), 0);
    chk("rst_Q", int'(o_Q), 0);
    idle(2);

    // Single frame, continuous input
    oq.delete();
    send_frame(0, 1'b0, t0);
    idle(12);
    chk("f1_cnt", oq.size(), 8);
    chk_frame("f1", 0, t0 + 2, 0);
    chk("hold_I", int'(o_I), 7);
    chk("hold_Q", int'(o_Q), -7);

    // Three frames back to back
    oq.delete();
    ovf_cnt = 0;
    send_frame(0, 1'b0, t0);
    send_frame(8, 1'b0, t1);
    send_frame(16, 1'b0, t2);
    idle(14);
    chk("b2b_cnt", oq.size(), 24);
    chk_frame("b2b0", 0, t0 + 2, 0);
    chk_frame("b2b1", 8, t0 + 10, 8);
    chk_frame("b2b2", 16, t0 + 18, 16);
    chk("b2b_ovf", ovf_cnt, 0);

    // Valid toggling 1,0,1,0
    oq.delete();
    send_frame(0, 1'b1, t0);
    send_frame(8, 1'b1, t1);
    idle(12);
    chk("gap_cnt", oq.size(), 16);
    chk_frame("gap0", 0, t0 + 2, 0);
    chk_frame("gap1", 8, t1 + 2, 8);

    // Reset after a partial frame
    oq.delete();
    for (int k = 0; k < 5; k++) put(1'b1, brv[k] + 40);
    i_init = 1'b1;
    put(1'b0, 0);
    i_init = 1'b0;
    idle(2);
    send_frame(16, 1'b0, t0);
    idle(14);
    chk("part_cnt", oq.size(), 8);
    chk_frame("part", 0, t0 + 2, 16);

    // Reset while output index 3 is on the port
    oq.delete();
    send_frame(24, 1'b0, t0);
    idle(4);
    i_init = 1'b1;
    tick();
    i_init = 1'b0;
    idle(20);
    chk("mrd_cnt", oq.size(), 4);
    if (oq.size() == 4) begin
      chk("mrd_last_cyc", oq[3].c, t0 + 5);
      chk("mrd_last_i", oq[3].i, 27);
    end
    oq.delete();
    send_frame(8, 1'b0, t1);
    idle(12);
    chk("mrd_new_cnt", oq.size(), 8);
    chk_frame("mrd_new", 0, t1 + 2, 8);

    // Overflow with the reader held off: both banks READY, one more sample
    oq.delete();
    ovf_cnt = 0;
    force dut.rd_pick = 1'b0;
    send_frame(32, 1'b0, t0);
    send_frame(40, 1'b0, t1);
    t2 = cyc;
    put(1'b1, 99);
    idle(5);
    chk("ovf_noout", oq.size(), 0);
    chk("ovf_cnt", ovf_cnt, 1);
    chk("ovf_cyc", ovf_cyc, t2 + 1);
    release dut.rd_pick;
    idle(30);
    chk("ovf_rd_cnt", oq.size(), 16);
    chk_frame("ovf_a", 0, -1, 32);
    chk_frame("ovf_b", 8, -1, 40);
    if (oq.size() == 16) chk("ovf_contig", oq[15].c - oq[0].c, 15);
    chk("ovf_cnt_end", ovf_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
